div_cfg_sequencer: RTL and testbench

// - Shares one frequency divider between NREQ requesters; each requester asks for a new divide ratio.
// - Round-robin arbitration; winner's value applied via disable -> settle -> load -> re-enable.
// - Sits between clock-control clients and the divider's DIN_n/CONFIG_DIV/ENABLE pins.
// - Divider loads only when ENABLE=0, so every reprogram is glitch-free and divider counter restarts from 0.

---
 rtl/div_cfg_sequencer_pkg.sv | 17 +
 rtl/div_cfg_sequencer_rr_arbiter.sv | 31 +++
 rtl/div_cfg_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_div_cfg_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/div_cfg_sequencer_pkg.sv
// div_ctrl_pkg: shared definitions for the divider configuration sequencer.
//   state_t   - sequencer FSM states
//   DIV_W_DEF - default divide-ratio width
//   RATIO_MIN - smallest legal ratio; a requested 0 is clamped to this
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    LOAD = 2'd2,
    ACKS = 2'd3
  } state_t;

  localparam int DIV_W_DEF = 32;
  localparam int RATIO_MIN = 1;

endpackage

// File: rtl/div_cfg_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req   in  N      request vector
//   last  in  IDX_W  index of the most recently served requester
//   grant out N      one-hot grant; search starts at last+1 and wraps,
//                    all-zero when no request is pending
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    // Offset k walks priority order last+1, last+2, ... wrapping back to last.
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(last) + k) % N) == i)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/div_cfg_sequencer.sv
// div_cfg_sequencer: shares one frequency divider between NREQ requesters.
// A round-robin winner's ratio is applied by dropping ENABLE, waiting GAP_CYC
// cycles, pulsing CONFIG with the new DIN for one cycle, then acknowledging
// and restoring ENABLE from RUN.
//   CLK, RESET_N   clock, asynchronous active-low reset
//   RUN            run request for the divided clock
//   REQ / DIV_VAL  per-requester level request and ratio ([i*DIV_W +: DIV_W])
//   ACK            one-cycle pulse to the served requester
//   BUSY           high from acceptance through the ACK cycle
//   ZERO_FIX       pulses with ACK when a requested 0 was clamped to 1
//   CUR_DIV        ratio currently programmed into the divider
//   DIV_DIN / DIV_CONFIG / DIV_ENABLE  divider pins, all registered
//
// state | meaning
// IDLE  | ENABLE follows RUN; arbitrate and accept a request
// GAP   | ENABLE held low for GAP_CYC cycles so the divider stops cleanly
// LOAD  | CONFIG high for one cycle with DIN = latched ratio
// ACKS  | ACK/ZERO_FIX pulse, CUR_DIV updated, ENABLE re-sampled from RUN
module div_cfg_sequencer
  import div_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int GAP_CYC = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  RUN,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*DIV_W-1:0] DIV_VAL,
  output logic [NREQ-1:0]       ACK,
  output logic                  BUSY,
  output logic                  ZERO_FIX,
  output logic [DIV_W-1:0]      CUR_DIV,
  output logic [DIV_W-1:0]      DIV_DIN,
  output logic                  DIV_CONFIG,
  output logic                  DIV_ENABLE
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(GAP_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NREQ - 1);
  localparam logic [DIV_W-1:0] RATIO_ONE = DIV_W'(RATIO_MIN);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [DIV_W-1:0]  val_q, val_d;
  logic              zero_q, zero_d;

  logic              en_q, en_d;
  logic              cfg_q, cfg_d;
  logic [DIV_W-1:0]  din_q, din_d;
  logic [DIV_W-1:0]  cur_q, cur_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              zf_q, zf_d;

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  gidx;
  logic [DIV_W-1:0]  gval;
  logic              accept;

  rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_arb (
    .req   (REQ),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    gval = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gidx = IDX_W'(i);
        gval = DIV_VAL[i*DIV_W +: DIV_W];
      end
    end
    accept = (state_q == IDLE) && (|REQ);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= LAST_RST;
      val_q   <= RATIO_ONE;
      zero_q  <= 1'b0;
      en_q    <= 1'b0;
      cfg_q   <= 1'b0;
      din_q   <= RATIO_ONE;
      cur_q   <= RATIO_ONE;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      val_q   <= val_d;
      zero_q  <= zero_d;
      en_q    <= en_d;
      cfg_q   <= cfg_d;
      din_q   <= din_d;
      cur_q   <= cur_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      zf_q    <= zf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    val_d   = val_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYC);
          idx_d   = gidx;
          // The divider cannot divide by 0; clamp and flag it.
          if (gval == '0) begin
            val_d  = RATIO_ONE;
            zero_d = 1'b1;
          end else begin
            val_d  = gval;
            zero_d = 1'b0;
          end
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOAD: state_d = ACKS;
      ACKS: begin
        state_d = IDLE;
        last_d  = idx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each pin is valid in the
  // same cycle the FSM occupies the corresponding state.
  always_comb begin
    en_d   = 1'b0;
    cfg_d  = (state_d == LOAD);
    din_d  = (state_d == LOAD) ? val_q : din_q;
    cur_d  = (state_d == ACKS) ? val_q : cur_q;
    zf_d   = (state_d == ACKS) && zero_q;
    busy_d = busy_q;
    ack_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack_d[i] = (state_d == ACKS) && (idx_q == IDX_W'(i));
    end
    case (state_q)
      IDLE: begin
        en_d = accept ? 1'b0 : RUN;
        if (accept) busy_d = 1'b1;
      end
      ACKS: begin
        en_d   = RUN;
        busy_d = 1'b0;
      end
      default: en_d = 1'b0;
    endcase
  end

  assign ACK        = ack_q;
  assign BUSY       = busy_q;
  assign ZERO_FIX   = zf_q;
  assign CUR_DIV    = cur_q;
  assign DIV_DIN    = din_q;
  assign DIV_CONFIG = cfg_q;
  assign DIV_ENABLE = en_q;

endmodule

// File: tb/tb_div_cfg_sequencer.sv
// Directed bench for div_cfg_sequencer with NREQ=2, DIV_W=32, GAP_CYC=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_div_cfg_sequencer;

  logic        CLK;
  logic        RESET_N;
  logic        RUN;
  logic [1:0]  REQ;
  logic [63:0] DIV_VAL;
  logic [1:0]  ACK;
  logic        BUSY;
  logic        ZERO_FIX;
  logic [31:0] CUR_DIV;
  logic [31:0] DIV_DIN;
  logic        DIV_CONFIG;
  logic        DIV_ENABLE;

  int errors = 0;
  int checks = 0;

  div_cfg_sequencer #(.NREQ(2), .DIV_W(32), .GAP_CYC(2)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .RUN        (RUN),
    .REQ        (REQ),
    .DIV_VAL    (DIV_VAL),
    .ACK        (ACK),
    .BUSY       (BUSY),
    .ZERO_FIX   (ZERO_FIX),
    .CUR_DIV    (CUR_DIV),
    .DIV_DIN    (DIV_DIN),
    .DIV_CONFIG (DIV_CONFIG),
    .DIV_ENABLE (DIV_ENABLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Waits up to 20 falling edges for an ACK; a=0 means the bound expired.
  task automatic wait_ack(output logic [1:0] a, output int n);
    a = 2'b00;
    n = 0;
    while (n < 20) begin
      @(negedge CLK);
      n++;
      if (ACK !== 2'b00) begin
        a = ACK;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; RUN = 1'b0; REQ = 2'b00; DIV_VAL = '0;
    repeat (2) @(negedge CLK);
    checks++; if (DIV_ENABLE !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", DIV_ENABLE); end
    checks++; if (DIV_CONFIG !== 1'b0) begin errors++; $display("FAIL rst_cfg: got %b want 0", DIV_CONFIG); end
    checks++; if (DIV_DIN !== 32'd1) begin errors++; $display("FAIL rst_din: got %0d want 1", DIV_DIN); end
    checks++; if (CUR_DIV !== 32'd1) begin errors++; $display("FAIL rst_cur: got %0d want 1", CUR_DIV); end
    checks++; if ({ACK, BUSY, ZERO_FIX} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {ACK, BUSY, ZERO_FIX}); end
    RESET_N = 1'b1; RUN = 1'b1;
    @(negedge CLK);
    checks++; if (DIV_ENABLE !== 1'b1) begin errors++; $display("FAIL run_en: got %b want 1", DIV_ENABLE); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (DIV_CONFIG !== 1'b0 || CUR_DIV !== 32'd1) begin errors++; $display("FAIL run_idle: cfg %b cur %0d want 0/1", DIV_CONFIG, CUR_DIV); end
    end
  endtask

  task automatic test_single();
    REQ = 2'b01; DIV_VAL = {32'd0, 32'd5};
    @(negedge CLK);
    checks++; if (DIV_ENABLE !== 1'b0 || BUSY !== 1'b1 || DIV_CONFIG !== 1'b0) begin errors++; $display("FAIL single_c1: en %b busy %b cfg %b want 0/1/0", DIV_ENABLE, BUSY, DIV_CONFIG); end
    DIV_VAL = {32'd0, 32'd9};
    @(negedge CLK);
    checks++; if (DIV_ENABLE !== 1'b0 || DIV_CONFIG !== 1'b0) begin errors++; $display("FAIL single_c2: en %b cfg %b want 0/0", DIV_ENABLE, DIV_CONFIG); end
    @(negedge CLK);
    checks++; if (DIV_CONFIG !== 1'b1 || DIV_ENABLE !== 1'b0) begin errors++; $display("FAIL single_load: cfg %b en %b want 1/0", DIV_CONFIG, DIV_ENABLE); end
    checks++; if (DIV_DIN !== 32'd5) begin errors++; $display("FAIL single_din: got %0d want 5", DIV_DIN); end
    checks++; if (ACK !== 2'b00) begin errors++; $display("FAIL single_early_ack: got %b want 00", ACK); end
    @(negedge CLK);
    checks++; if (ACK !== 2'b01) begin errors++; $display("FAIL single_ack: got %b want 01", ACK); end
    checks++; if (CUR_DIV !== 32'd5) begin errors++; $display("FAIL single_cur: got %0d want 5", CUR_DIV); end
    checks++; if (DIV_CONFIG !== 1'b0 || BUSY !== 1'b1 || ZERO_FIX !== 1'b0) begin errors++; $display("FAIL single_acks: cfg %b busy %b zf %b want 0/1/0", DIV_CONFIG, BUSY, ZERO_FIX); end
    REQ = 2'b00;
    @(negedge CLK);
    checks++; if (DIV_ENABLE !== 1'b1) begin errors++; $display("FAIL single_reen: got %b want 1", DIV_ENABLE); end
    checks++; if (ACK !== 2'b00 || BUSY !== 1'b0 || DIV_DIN !== 32'd5) begin errors++; $display("FAIL single_after: ack %b busy %b din %0d want 00/0/5", ACK, BUSY, DIV_DIN); end
  endtask

  task automatic test_zero_fix();
    REQ = 2'b10; DIV_VAL = {32'd0, 32'd9};
    @(negedge CLK);
    @(negedge CLK);
    RUN = 1'b0;
    @(negedge CLK);
    checks++; if (DIV_CONFIG !== 1'b1 || DIV_DIN !== 32'd1) begin errors++; $display("FAIL zero_load: cfg %b din %0d want 1/1", DIV_CONFIG, DIV_DIN); end
    @(negedge CLK);
    checks++; if (ACK !== 2'b10 || ZERO_FIX !== 1'b1) begin errors++; $display("FAIL zero_ack: ack %b zf %b want 10/1", ACK, ZERO_FIX); end
    checks++; if (CUR_DIV !== 32'd1) begin errors++; $display("FAIL zero_cur: got %0d want 1", CUR_DIV); end
    REQ = 2'b00;
    @(negedge CLK);
    checks++; if (ZERO_FIX !== 1'b0 || ACK !== 2'b00) begin errors++; $display("FAIL zero_pulse: zf %b ack %b want 0/00", ZERO_FIX, ACK); end
    checks++; if (DIV_ENABLE !== 1'b0) begin errors++; $display("FAIL zero_run_off: en %b want 0", DIV_ENABLE); end
    RUN = 1'b1;
    @(negedge CLK);
    checks++; if (DIV_ENABLE !== 1'b1) begin errors++; $display("FAIL zero_run_on: en %b want 1", DIV_ENABLE); end
  endtask

  task automatic test_both();
    logic [1:0] a;
    int n;
    REQ = 2'b11; DIV_VAL = {32'd7, 32'd3};
    wait_ack(a, n);
    checks++; if (a !== 2'b01 || n != 4) begin errors++; $display("FAIL both_first: ack %b after %0d want 01 after 4", a, n); end
    checks++; if (CUR_DIV !== 32'd3) begin errors++; $display("FAIL both_cur0: got %0d want 3", CUR_DIV); end
    REQ = 2'b10;
    wait_ack(a, n);
    checks++; if (a !== 2'b10 || n != 5) begin errors++; $display("FAIL both_second: ack %b after %0d want 10 after 5", a, n); end
    checks++; if (CUR_DIV !== 32'd7) begin errors++; $display("FAIL both_cur1: got %0d want 7", CUR_DIV); end
    REQ = 2'b00;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0 || ACK !== 2'b00) begin errors++; $display("FAIL both_idle: busy %b ack %b want 0/00", BUSY, ACK); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] a;
    logic [1:0] exp_a;
    int n;
    REQ = 2'b11; DIV_VAL = {32'd22, 32'd11};
    for (int k = 0; k < 4; k++) begin
      exp_a = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_ack(a, n);
      checks++; if (a !== exp_a || n != ((k == 0) ? 4 : 5)) begin errors++; $display("FAIL alt_grant%0d: ack %b after %0d want %b", k, a, n, exp_a); end
      checks++; if (CUR_DIV !== ((exp_a == 2'b01) ? 32'd11 : 32'd22)) begin errors++; $display("FAIL alt_cur%0d: got %0d", k, CUR_DIV); end
      REQ[0] = (a != 2'b01);
    end
    REQ = 2'b00;
    repeat (2) @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL alt_idle: busy %b want 0", BUSY); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] a;
    int n;
    logic saw_ack;
    REQ = 2'b01; DIV_VAL = {32'd0, 32'd9};
    repeat (3) @(negedge CLK);
    checks++; if (DIV_CONFIG !== 1'b1) begin errors++; $display("FAIL mid_load: cfg %b want 1", DIV_CONFIG); end
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (DIV_CONFIG !== 1'b0 || DIV_ENABLE !== 1'b0) begin errors++; $display("FAIL mid_rst_pins: cfg %b en %b want 0/0", DIV_CONFIG, DIV_ENABLE); end
    checks++; if (CUR_DIV !== 32'd1 || DIV_DIN !== 32'd1 || BUSY !== 1'b0) begin errors++; $display("FAIL mid_rst_state: cur %0d din %0d busy %b want 1/1/0", CUR_DIV, DIV_DIN, BUSY); end
    REQ = 2'b00;
    saw_ack = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (ACK !== 2'b00) saw_ack = 1'b1;
    end
    RESET_N = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (ACK !== 2'b00) saw_ack = 1'b1;
    end
    checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL mid_no_ack: saw ack %b want 0", saw_ack); end
    checks++; if (DIV_ENABLE !== 1'b1 || CUR_DIV !== 32'd1) begin errors++; $display("FAIL mid_recover: en %b cur %0d want 1/1", DIV_ENABLE, CUR_DIV); end
    REQ = 2'b01; DIV_VAL = {32'd0, 32'd6};
    wait_ack(a, n);
    checks++; if (a !== 2'b01 || n != 4) begin errors++; $display("FAIL mid_rereq: ack %b after %0d want 01 after 4", a, n); end
    checks++; if (CUR_DIV !== 32'd6) begin errors++; $display("FAIL mid_cur: got %0d want 6", CUR_DIV); end
    REQ = 2'b00;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_fix();
    test_both();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
